// File: rtl/tm_multiclass_engine.sv
// Multi-class Tsetlin machine engine: shared clause/chunk sequencer, signed class sums, sequential argmax.
// Optional build macro TM_SUM_CLAMP_EN saturates each class sum to [-THRESHOLD, +THRESHOLD].
module tm_multiclass_engine #(
  parameter int unsigned           N_CLASSES = 10,
  parameter int unsigned           CLAUSES   = 2000,
  parameter int unsigned           LA_CHUNKS = 49,
  parameter int unsigned           INT_SIZE  = 32,
  parameter logic [INT_SIZE-1:0]   FILTER    = '1,
  parameter int                    THRESHOLD = 15
) (
  input  logic                            clk,
  input  logic                            rst_flag,
  input  logic                            start,
  input  logic [INT_SIZE-1:0]             xin,
  input  logic [N_CLASSES*INT_SIZE-1:0]   ta_include,
  output logic [$clog2(CLAUSES)-1:0]      clause_idx,
  output logic [$clog2(LA_CHUNKS)-1:0]    chunk_idx,
  output logic [N_CLASSES*INT_SIZE-1:0]   class_sums,
  output logic [$clog2(N_CLASSES)-1:0]    pred_class,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned CW = $clog2(CLAUSES);
  localparam int unsigned KW = $clog2(LA_CHUNKS);
  localparam int unsigned PW = $clog2(N_CLASSES);
  localparam logic [CW-1:0] LAST_CLAUSE = CW'(CLAUSES - 1);
  localparam logic [KW-1:0] LAST_CHUNK  = KW'(LA_CHUNKS - 1);
  localparam logic [PW-1:0] LAST_CLASS  = PW'(N_CLASSES - 1);
  localparam logic signed [INT_SIZE-1:0] ONE    = INT_SIZE'(1);
  localparam logic signed [INT_SIZE-1:0] SAT_HI = INT_SIZE'(THRESHOLD);
  localparam logic signed [INT_SIZE-1:0] SAT_LO = -SAT_HI;

`ifdef TM_SUM_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ARGMAX, S_DONE} state_t;
  state_t state, state_nxt;

  logic signed [INT_SIZE-1:0] sums_q [N_CLASSES];
  logic signed [INT_SIZE-1:0] best_val;
  logic [PW-1:0]              best_idx, arg_idx;
  logic [N_CLASSES-1:0]       ok_q, any_q, ok_cur, any_cur;
  logic                       first_chunk, last_chunk, last_pair, arg_last, better;

  // Flag reset at clause start is folded into the combinational update so
  // chunk 0 evaluates against fresh 1/0 values without an extra cycle.
  always_comb begin
    logic [INT_SIZE-1:0] inc_m, viol_m;
    inc_m       = '0;
    viol_m      = '0;
    ok_cur      = '0;
    any_cur     = '0;
    first_chunk = (chunk_idx == '0);
    last_chunk  = (chunk_idx == LAST_CHUNK);
    last_pair   = last_chunk && (clause_idx == LAST_CLAUSE);
    arg_last    = (arg_idx == LAST_CLASS);
    better      = (arg_idx == '0) || (sums_q[arg_idx] > best_val);
    for (int unsigned k = 0; k < N_CLASSES; k++) begin
      inc_m = ta_include[k*INT_SIZE +: INT_SIZE];
      if (last_chunk) inc_m = inc_m & FILTER;
      viol_m     = inc_m & ~xin;
      ok_cur[k]  = (first_chunk | ok_q[k]) & ~(|viol_m);
      any_cur[k] = (~first_chunk & any_q[k]) | (|inc_m);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (last_pair) state_nxt = S_ARGMAX;
      S_ARGMAX: if (arg_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_flag) begin
    if (!rst_flag) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_flag) begin
    if (!rst_flag) begin
      clause_idx <= '0;
      chunk_idx  <= '0;
      ok_q       <= '0;
      any_q      <= '0;
      arg_idx    <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      pred_class <= '0;
      for (int unsigned k = 0; k < N_CLASSES; k++) sums_q[k] <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          clause_idx <= '0;
          chunk_idx  <= '0;
          ok_q       <= '1;
          any_q      <= '0;
          arg_idx    <= '0;
          for (int unsigned k = 0; k < N_CLASSES; k++) sums_q[k] <= '0;
        end
        S_RUN: begin
          ok_q  <= ok_cur;
          any_q <= any_cur;
          if (last_chunk) begin
            for (int unsigned k = 0; k < N_CLASSES; k++) begin
              if (ok_cur[k] && any_cur[k]) begin
                if (!clause_idx[0]) begin
                  if (!(CLAMP && sums_q[k] >= SAT_HI)) sums_q[k] <= sums_q[k] + ONE;
                end else begin
                  if (!(CLAMP && sums_q[k] <= SAT_LO)) sums_q[k] <= sums_q[k] - ONE;
                end
              end
            end
          end
          if (last_pair) begin
            clause_idx <= '0;
            chunk_idx  <= '0;
          end else if (last_chunk) begin
            chunk_idx  <= '0;
            clause_idx <= clause_idx + 1'b1;
          end else begin
            chunk_idx  <= chunk_idx + 1'b1;
          end
        end
        S_ARGMAX: begin
          if (better) begin
            best_val <= sums_q[arg_idx];
            best_idx <= arg_idx;
          end
          if (arg_last) begin
            arg_idx    <= '0;
            pred_class <= better ? arg_idx : best_idx;
          end else begin
            arg_idx <= arg_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    class_sums = '0;
    for (int unsigned k = 0; k < N_CLASSES; k++)
      class_sums[k*INT_SIZE +: INT_SIZE] = sums_q[k];
    busy = (state == S_RUN) || (state == S_ARGMAX);
    done = (state == S_DONE);
  end

endmodule

// File: doc/tm_multiclass_engine.md
# tm_multiclass_engine

Parametrised successor to the fixed ten-class classifier. Evaluates all clauses of `N_CLASSES` Tsetlin machines in lock-step from one shared clause/chunk sequencer, accumulates signed class sums, and performs a sequential argmax to produce a predicted class. It sits between the per-class TA-state ROMs and the XIN ROM, and the result consumer. It adds the following, all absent from the previous generation:
- start/busy/done handshake
- empty-clause suppression
- argmax output
- optional threshold clamping

## Interface
Parameters:
- `N_CLASSES`, 10: number of class TMs evaluated in parallel (≥2).
- `CLAUSES`, 2000: clauses per class; even index = positive polarity, odd = negative.
- `LA_CHUNKS`, 49: literal chunks per clause.
- `INT_SIZE`, 32: chunk width and class-sum width.
- `FILTER`, 32'hFFFFFFFF: valid-literal mask applied to chunk `LA_CHUNKS-1` only.
- `THRESHOLD`, 15: clamp magnitude (used only with `TM_SUM_CLAMP_EN`).

Ports:
- `clk`, in, 1: clock.
- `rst_flag`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `xin`, in, `INT_SIZE`: literal chunk at `chunk_idx`; combinational ROM data.
- `ta_include`, in, `N_CLASSES*INT_SIZE`: include masks for (`clause_idx`, `chunk_idx`). Class k occupies bits [k*INT_SIZE +: INT_SIZE].
- `clause_idx`, out, `$clog2(CLAUSES)`: ROM clause address.
- `chunk_idx`, out, `$clog2(LA_CHUNKS)`: ROM chunk address / offset.
- `class_sums`, out, `N_CLASSES*INT_SIZE`: signed sums, same packing as `ta_include`.
- `pred_class`, out, `$clog2(N_CLASSES)`: index of maximum sum.
- `busy`, out, 1: high from first RUN cycle until DONE.
- `done`, out, 1: one-cycle pulse when results are valid.

## Operation
- States and transitions:
  - IDLE → RUN on `start`. On that edge, clear indices, class sums and per-class clause flags.
  - RUN → ARGMAX after the last pair.
  - ARGMAX → DONE after `N_CLASSES` cycles.
  - DONE → IDLE unconditionally.
- RUN, one (clause, chunk) pair per cycle:
  - `chunk_idx` increments.
  - When `chunk_idx == LA_CHUNKS-1` it wraps to 0 and `clause_idx` increments.
  - The last pair is (`CLAUSES-1`, `LA_CHUNKS-1`).
- Per class, per cycle:
  - `viol = inc & ~xin`, and `nonempty = |inc`.
  - On chunk `LA_CHUNKS-1`, both `inc` and `viol` are first masked with `FILTER`.
  - Registered flags: `ok &= (viol==0)` and `any |= nonempty`. Both reset to 1/0 at clause start.
- Clause commit, on the last chunk edge:
  - `out = ok_final & any_final`; empty clauses contribute 0.
  - If `out` is set, the sum is incremented when `clause_idx` is even and decremented when it is odd.
- Arithmetic: signed `INT_SIZE` two's complement; no overflow handling without the clamp.
- ARGMAX:
  - Scans classes 0..N-1, one per cycle.
  - Strict `>` comparison, so on ties the lowest index wins.
  - `pred_class` updates only at the DONE transition.
- `start` during RUN, ARGMAX or DONE is ignored. `class_sums` and `pred_class` hold their values from DONE until the next accepted `start`.
- `clause_idx` and `chunk_idx` read 0 outside RUN.

## Timing
- Reset value of every output is 0: `clause_idx`, `chunk_idx`, `class_sums`, `pred_class`, `busy`, `done`. State resets to IDLE.
- Reset assertion mid-operation aborts immediately, clears all outputs, and drops `busy` asynchronously.
- With `start` sampled at edge 0:
  - RUN occupies cycles 1..`CLAUSES*LA_CHUNKS`.
  - ARGMAX occupies the next `N_CLASSES` cycles.
  - `done` is high in cycle `CLAUSES*LA_CHUNKS+N_CLASSES+1`.
- ROM data is consumed in the same cycle its address is presented; there is zero read latency.
- The final class sum is visible from the first ARGMAX cycle.
- `busy` falls together with `done` rising.
- A `start` in the same cycle as `done` is ignored. The earliest re-accept is the following IDLE cycle.

## Configuration
- `TM_SUM_CLAMP_EN` defined:
  - Each committed sum saturates to [-`THRESHOLD`, +`THRESHOLD`].
  - An increment at +T or a decrement at -T holds the value.
- `TM_SUM_CLAMP_EN` undefined: unclamped signed accumulation, and `THRESHOLD` is unused.

## Test plan
All scenarios use `N_CLASSES=3`, `CLAUSES=4`, `LA_CHUNKS=2`, `INT_SIZE=8` and `FILTER=8'h0F` unless stated otherwise.

1. Latency check.
   - Stimulus: all includes 0, `start` pulse.
   - Required response: `busy` cycles 1-11, `done` at cycle 12; all sums 0, because empty clauses are suppressed; `pred_class`=0.
2. Polarity accumulation.
   - Stimulus: `xin`=8'hFF. Class 1 includes bit 0 in clauses 0, 1 and 2; class 2 includes bit 0 in clause 3 only.
   - Required response: sums {0, +1, -1}, `pred_class`=1.
3. FILTER masking.
   - Stimulus: class 0 includes bit 7 in chunk 1 of clause 0, with `xin` bit 7 = 0.
   - Required response: the clause is treated as empty, so sum0 = 0. With the include on bit 3 and `xin` bit 3 = 1, sum0 = +1.
4. Clamp behaviour.
   - Stimulus: `CLAUSES=40`, `THRESHOLD=5`, class 0 firing on all even clauses.
   - Required response: sum0 = 5 with `TM_SUM_CLAMP_EN`, and 20 without it.
5. Tie-break and start-while-busy.
   - Stimulus: equal sums on classes 1 and 2, with an extra `start` at cycle 5.
   - Required response: `pred_class`=1; the extra `start` is ignored and `done` still occurs at cycle 12.
6. Reset mid-run.
   - Stimulus: assert `rst_flag` low at cycle 6, release it, then pulse `start`.
   - Required response: all outputs go to 0 immediately; the new run completes with correct sums and no residue from the aborted run.
